// File: rtl/simmem_pkg.sv
// Shared sizing and types for the simulated-memory response path.
// Slot identifiers index the write-response delay bank.
package simmem_pkg;

  localparam int WriteRespBankTotalCapacity = 16;
  localparam int NumSlots = WriteRespBankTotalCapacity;
  localparam int SlotIdWidth = $clog2(NumSlots);

  typedef logic [SlotIdWidth-1:0] slot_id_t;
  typedef logic [NumSlots-1:0] slot_mask_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + start pointer
// to onehot grant, grant index and grant-valid.
module simmem_rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] cand;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_i + W'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  assign gnt_o = valid_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/simmem_delay_release_scheduler.sv
// Write-response delay bank scheduler: slot allocation, round-robin
// release arbitration and a one-entry registered output stage.
module simmem_delay_release_scheduler #(
  parameter int NumSlots = simmem_pkg::WriteRespBankTotalCapacity,
  localparam int SlotIdWidth = $clog2(NumSlots)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  output logic [SlotIdWidth-1:0] alloc_id_o,
  input  logic [NumSlots-1:0]    release_en_i,
  output logic [NumSlots-1:0]    address_released_onehot_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [SlotIdWidth-1:0] out_id_o,
  output logic [SlotIdWidth:0]   occupancy_o
);

  logic [NumSlots-1:0]    in_use_q;
  logic [SlotIdWidth-1:0] rr_ptr_q;
  logic [NumSlots-1:0]    pending;
  logic [NumSlots-1:0]    eligible;
  logic [NumSlots-1:0]    gnt_oh;
  logic [SlotIdWidth-1:0] gnt_idx;
  logic                   gnt_valid;
  logic                   alloc_fire;
  logic                   out_fire;
  logic                   load;

  assign alloc_ready_o = |(~in_use_q);

  always_comb begin
    alloc_id_o = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!in_use_q[i]) alloc_id_o = SlotIdWidth'(i);
    end
  end

  // The entry sitting in the output stage must not be granted twice.
  assign pending  = out_valid_o ? (NumSlots'(1) << out_id_o) : '0;
  assign eligible = release_en_i & in_use_q & ~pending;

  simmem_rr_arbiter #(
    .N(NumSlots)
  ) u_arb (
    .req_i  (eligible),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  assign alloc_fire = alloc_valid_i & alloc_ready_o;
  assign out_fire   = out_valid_o & out_ready_i;
  assign load       = ~out_valid_o | out_fire;

  assign address_released_onehot_o =
    (load & gnt_valid) ? gnt_oh : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_use_q    <= '0;
      rr_ptr_q    <= '0;
      out_valid_o <= 1'b0;
      out_id_o    <= '0;
      occupancy_o <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (out_fire && out_id_o == SlotIdWidth'(i))
          in_use_q[i] <= 1'b0;
        else if (alloc_fire && alloc_id_o == SlotIdWidth'(i))
          in_use_q[i] <= 1'b1;
      end
      occupancy_o <= occupancy_o
                   + (SlotIdWidth + 1)'(alloc_fire)
                   - (SlotIdWidth + 1)'(out_fire);
      if (load) begin
        if (gnt_valid) begin
          out_valid_o <= 1'b1;
          out_id_o    <= gnt_idx;
          rr_ptr_q    <= gnt_idx + SlotIdWidth'(1);
        end else begin
          out_valid_o <= 1'b0;
        end
      end
    end
  end

  a_release_in_use : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (release_en_i & ~in_use_q) == '0);

  a_ack_onehot0 : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0(address_released_onehot_o));

  a_occ_count : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    occupancy_o == (SlotIdWidth + 1)'($countones(in_use_q)));

endmodule
